// File: rtl/axisr_chksum_append.sv
// Inline AXI4-Stream checksum appender: forwards each packet and appends one trailer beat
// holding the inverted 32-bit ones'-complement sum per tid. Optional counters: CHKSUM_STATS_EN.
module axisr_chksum_append #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6,
    parameter int N_CH   = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic [ID_W-1:0]       s_axis_tid,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic [ID_W-1:0]       m_axis_tid,
    output logic                  m_axis_tlast
`ifdef CHKSUM_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           bypass_count
`endif
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int LANES  = DATA_W / 32;
    localparam int SUM_W  = 32 + $clog2(LANES) + 1;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {PASS, TRAILER} state_t;

    state_t              state_q, state_d;
    logic [31:0]         acc_q [N_CH];
    logic [31:0]         acc_d [N_CH];
    logic [31:0]         fin_q, fin_d;
    logic [ID_W-1:0]     trl_tid_q, trl_tid_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [KEEP_W-1:0]   keep_q, keep_d;
    logic [ID_W-1:0]     tid_q, tid_d;
    logic                last_q, last_d;

    logic                out_free;
    logic                s_hs;
    logic                in_range;
    logic [CH_W-1:0]     ch_idx;
    logic [31:0]         beat_sum;
    logic [31:0]         acc_new;

    function automatic logic [31:0] fold32(input logic [SUM_W-1:0] x);
        logic [SUM_W-1:0] t;
        t = x;
        for (int i = 0; i < 3; i++) begin
            t = SUM_W'(t[31:0]) + (t >> 32);
        end
        return t[31:0];
    endfunction

    function automatic logic [31:0] beat_sum_f(input logic [DATA_W-1:0] d,
                                               input logic [KEEP_W-1:0] k);
        logic [SUM_W-1:0] s;
        logic [31:0]      lane;
        s = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < 4; b++) begin
                lane[8*b +: 8] = k[4*l+b] ? d[32*l+8*b +: 8] : 8'h00;
            end
            s = s + SUM_W'(lane);
        end
        return fold32(s);
    endfunction

    assign out_free      = !vld_q || m_axis_tready;
    // Ready is forced low while reset is held, independent of the registered state.
    assign s_axis_tready = areset && (state_q == PASS) && out_free;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign in_range      = {1'b0, s_axis_tid} < (ID_W + 1)'(N_CH);
    assign ch_idx        = s_axis_tid[CH_W-1:0];
    assign beat_sum      = beat_sum_f(s_axis_tdata, s_axis_tkeep);
    assign acc_new       = fold32(SUM_W'(acc_q[ch_idx]) + SUM_W'(beat_sum));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fin_d     = fin_q;
        trl_tid_d = trl_tid_q;
        vld_d     = vld_q;
        data_d    = data_q;
        keep_d    = keep_q;
        tid_d     = tid_q;
        last_d    = last_q;
        if (vld_q && m_axis_tready) begin
            vld_d = 1'b0;
        end
        case (state_q)
            PASS: begin
                if (s_hs) begin
                    vld_d  = 1'b1;
                    data_d = s_axis_tdata;
                    keep_d = s_axis_tkeep;
                    tid_d  = s_axis_tid;
                    last_d = s_axis_tlast;
                    if (in_range) begin
                        if (s_axis_tlast) begin
                            last_d         = 1'b0;
                            fin_d          = acc_new;
                            trl_tid_d      = s_axis_tid;
                            acc_d[ch_idx]  = '0;
                            state_d        = TRAILER;
                        end else begin
                            acc_d[ch_idx]  = acc_new;
                        end
                    end
                end
            end
            TRAILER: begin
                if (out_free) begin
                    vld_d       = 1'b1;
                    data_d      = '0;
                    data_d[31:0] = ~fin_q;
                    keep_d      = '0;
                    keep_d[3:0] = 4'hF;
                    tid_d       = trl_tid_q;
                    last_d      = 1'b1;
                    state_d     = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state_q   <= PASS;
            acc_q     <= '{default: '0};
            fin_q     <= '0;
            trl_tid_q <= '0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            tid_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fin_q     <= fin_d;
            trl_tid_q <= trl_tid_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            tid_q     <= tid_d;
            last_q    <= last_d;
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tlast  = last_q;

`ifdef CHKSUM_STATS_EN
    logic        trl_out_q, trl_out_d;
    logic [31:0] pkt_q, byp_q;

    // Marks that the output register currently holds a trailer beat.
    always_comb begin
        trl_out_d = trl_out_q;
        if (vld_q && m_axis_tready) begin
            trl_out_d = 1'b0;
        end
        if (state_q == TRAILER && out_free) begin
            trl_out_d = 1'b1;
        end else if (s_hs) begin
            trl_out_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            trl_out_q <= 1'b0;
            pkt_q     <= '0;
            byp_q     <= '0;
        end else begin
            trl_out_q <= trl_out_d;
            if (vld_q && m_axis_tready && trl_out_q) begin
                pkt_q <= pkt_q + 32'd1;
            end
            if (s_hs && s_axis_tlast && !in_range) begin
                byp_q <= byp_q + 32'd1;
            end
        end
    end

    assign pkt_count    = pkt_q;
    assign bypass_count = byp_q;
`endif

endmodule

// File: tb/tb_axisr_chksum_append.sv
// Directed bench for axisr_chksum_append: collects output handshakes in a queue and checks
// them against hand-computed beats; also checks hold-while-stalled and reset behaviour.
module tb_axisr_chksum_append;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int IW = 6;
    localparam logic [KW-1:0] KALL = {KW{1'b1}};

    logic          aclk = 1'b0;
    logic          areset = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [IW-1:0] s_axis_tid = '0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [IW-1:0] m_axis_tid;
    logic          m_axis_tlast;
`ifdef CHKSUM_STATS_EN
    logic [31:0]   pkt_count;
    logic [31:0]   bypass_count;
`endif

    axisr_chksum_append #(.DATA_W(DW), .ID_W(IW), .N_CH(4)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast)
`ifdef CHKSUM_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .bypass_count  (bypass_count)
`endif
    );

    always #5 aclk = ~aclk;

    logic rnd_rdy = 1'b0;
    always begin
        @(posedge aclk);
        #2;
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [IW-1:0] id;
        logic          l;
    } beat_t;

    beat_t               mq[$];
    int                  total = 0;
    int                  bad = 0;
    logic                stall_p = 1'b0;
    logic [DW+KW+IW:0]   held = '0;

    // Every falling edge goes through here: hold check plus output capture.
    task automatic step();
        logic [DW+KW+IW:0] cur;
        @(negedge aclk);
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast};
        if (!areset) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                total++;
                assert (m_axis_tvalid === 1'b1 && cur === held) else begin
                    bad++;
                    $error("FAIL hold: got v=%b %h want v=1 %h", m_axis_tvalid, cur, held);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                mq.push_back('{d: m_axis_tdata, k: m_axis_tkeep, id: m_axis_tid, l: m_axis_tlast});
            end
            stall_p = m_axis_tvalid && !m_axis_tready;
            held    = cur;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [IW-1:0] id, input logic l);
        int n;
        step();
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tid    = id;
        s_axis_tlast  = l;
        n = 0;
        step();
        while (!s_axis_tready && n < 200) begin
            n++;
            step();
        end
        total++;
        assert (s_axis_tready === 1'b1) else begin
            bad++;
            $error("FAIL send_timeout: got ready=%b want 1", s_axis_tready);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input logic [IW-1:0] id, input logic l);
        int    n;
        beat_t b;
        n = 0;
        while (mq.size() == 0 && n < 100) begin
            n++;
            step();
        end
        total++;
        assert (mq.size() != 0) else begin
            bad++;
            $error("FAIL %s_present: got 0 beats want 1", tag);
        end
        if (mq.size() != 0) begin
            b = mq.pop_front();
            total++;
            assert (b.d === d) else begin
                bad++;
                $error("FAIL %s_data: got %h want %h", tag, b.d, d);
            end
            total++;
            assert ({b.k, b.id, b.l} === {k, id, l}) else begin
                bad++;
                $error("FAIL %s_ctl: got k=%h id=%0d l=%b want k=%h id=%0d l=%b",
                       tag, b.k, b.id, b.l, k, id, l);
            end
        end
    endtask

    task automatic expect_empty(input string tag);
        for (int i = 0; i < 6; i++) step();
        total++;
        assert (mq.size() == 0) else begin
            bad++;
            $error("FAIL %s: got %0d extra beats want 0", tag, mq.size());
        end
    endtask

    function automatic logic [DW-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1);
        logic [DW-1:0] r;
        r = '0;
        r[31:0]  = l0;
        r[63:32] = l1;
        return r;
    endfunction

    function automatic logic [KW-1:0] trl_keep();
        logic [KW-1:0] r;
        r = '0;
        r[3:0] = 4'hF;
        return r;
    endfunction

    logic [DW-1:0] ones16;
    logic [DW-1:0] allset;

    initial begin
        for (int i = 0; i < DW / 32; i++) ones16[32*i +: 32] = 32'h1;
        allset = '1;

        // reset held
        step();
        step();
        total++;
        assert (m_axis_tvalid === 1'b0 && s_axis_tready === 1'b0) else begin
            bad++;
            $error("FAIL reset_vld_rdy: got v=%b r=%b want 0 0", m_axis_tvalid, s_axis_tready);
        end
        total++;
        assert ({m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast} === '0) else begin
            bad++;
            $error("FAIL reset_fields: got %h want 0", m_axis_tdata);
        end
        areset = 1'b1;
        step();

        // 16 lanes of 1
        send(ones16, KALL, 6'd0, 1'b1);
        expect_beat("t1_beat", ones16, KALL, 6'd0, 1'b0);
        expect_beat("t1_trl", lanes(32'hFFFFFFEF, 32'h0), trl_keep(), 6'd0, 1'b1);

        // end-around carry
        send(lanes(32'hFFFFFFFF, 32'h2), KALL, 6'd1, 1'b1);
        expect_beat("t2_beat", lanes(32'hFFFFFFFF, 32'h2), KALL, 6'd1, 1'b0);
        expect_beat("t2_trl", lanes(32'hFFFFFFFD, 32'h0), trl_keep(), 6'd1, 1'b1);

        // partial keep
        send(lanes(32'hAABBCCDD, 32'h0), 64'h3, 6'd2, 1'b1);
        expect_beat("t3_beat", lanes(32'hAABBCCDD, 32'h0), 64'h3, 6'd2, 1'b0);
        expect_beat("t3_trl", lanes(32'hFFFF3322, 32'h0), trl_keep(), 6'd2, 1'b1);

        // interleaved tid0 / tid1
        send(lanes(32'h1, 32'h0), KALL, 6'd0, 1'b0);
        send(lanes(32'h2, 32'h0), KALL, 6'd1, 1'b0);
        send(lanes(32'h1, 32'h0), KALL, 6'd0, 1'b0);
        send(lanes(32'h2, 32'h0), KALL, 6'd1, 1'b0);
        send(lanes(32'h1, 32'h0), KALL, 6'd0, 1'b1);
        send(lanes(32'h2, 32'h0), KALL, 6'd1, 1'b1);
        expect_beat("il_a0", lanes(32'h1, 32'h0), KALL, 6'd0, 1'b0);
        expect_beat("il_b0", lanes(32'h2, 32'h0), KALL, 6'd1, 1'b0);
        expect_beat("il_a1", lanes(32'h1, 32'h0), KALL, 6'd0, 1'b0);
        expect_beat("il_b1", lanes(32'h2, 32'h0), KALL, 6'd1, 1'b0);
        expect_beat("il_a2", lanes(32'h1, 32'h0), KALL, 6'd0, 1'b0);
        expect_beat("il_trl0", lanes(32'hFFFFFFFC, 32'h0), trl_keep(), 6'd0, 1'b1);
        expect_beat("il_b2", lanes(32'h2, 32'h0), KALL, 6'd1, 1'b0);
        expect_beat("il_trl1", lanes(32'hFFFFFFF9, 32'h0), trl_keep(), 6'd1, 1'b1);

        // tid0 restarts from zero
        send(lanes(32'h5, 32'h0), KALL, 6'd0, 1'b1);
        expect_beat("rs_beat", lanes(32'h5, 32'h0), KALL, 6'd0, 1'b0);
        expect_beat("rs_trl", lanes(32'hFFFFFFFA, 32'h0), trl_keep(), 6'd0, 1'b1);

        // all-zero packet
        send('0, KALL, 6'd2, 1'b1);
        expect_beat("z_beat", '0, KALL, 6'd2, 1'b0);
        expect_beat("z_trl", lanes(32'hFFFFFFFF, 32'h0), trl_keep(), 6'd2, 1'b1);

        // zero-keep beat contributes nothing
        send(allset, '0, 6'd3, 1'b0);
        send(lanes(32'h1, 32'h0), KALL, 6'd3, 1'b1);
        expect_beat("zk_b0", allset, '0, 6'd3, 1'b0);
        expect_beat("zk_b1", lanes(32'h1, 32'h0), KALL, 6'd3, 1'b0);
        expect_beat("zk_trl", lanes(32'hFFFFFFFE, 32'h0), trl_keep(), 6'd3, 1'b1);

        // bypass tid
        send(lanes(32'h12345678, 32'h9), KALL, 6'd5, 1'b1);
        expect_beat("byp_beat", lanes(32'h12345678, 32'h9), KALL, 6'd5, 1'b1);
        expect_empty("byp_no_trl");
`ifdef CHKSUM_STATS_EN
        total++;
        assert (pkt_count === 32'd8 && bypass_count === 32'd1) else begin
            bad++;
            $error("FAIL stats1: got pkt=%0d byp=%0d want 8 1", pkt_count, bypass_count);
        end
`endif

        // random output backpressure
        rnd_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) send(lanes(32'(i), 32'h0), KALL, 6'd1, i == 4);
        for (int i = 1; i <= 4; i++) expect_beat("rr_beat", lanes(32'(i), 32'h0), KALL, 6'd1, 1'b0);
        expect_beat("rr_trl", lanes(32'hFFFFFFF5, 32'h0), trl_keep(), 6'd1, 1'b1);

        // reset in the middle of a tid2 packet
        send(lanes(32'h7, 32'h0), KALL, 6'd2, 1'b0);
        send(lanes(32'h8, 32'h0), KALL, 6'd2, 1'b0);
        expect_beat("pr_b0", lanes(32'h7, 32'h0), KALL, 6'd2, 1'b0);
        expect_beat("pr_b1", lanes(32'h8, 32'h0), KALL, 6'd2, 1'b0);
        #1;
        areset = 1'b0;
        #1;
        total++;
        assert (m_axis_tvalid === 1'b0 && s_axis_tready === 1'b0 && m_axis_tdata === '0) else begin
            bad++;
            $error("FAIL midreset: got v=%b r=%b want 0 0", m_axis_tvalid, s_axis_tready);
        end
        step();
        step();
        areset = 1'b1;
        step();
        total++;
        assert (m_axis_tvalid === 1'b0) else begin
            bad++;
            $error("FAIL post_reset_vld: got %b want 0", m_axis_tvalid);
        end
        send(lanes(32'h3, 32'h0), KALL, 6'd2, 1'b1);
        expect_beat("po_beat", lanes(32'h3, 32'h0), KALL, 6'd2, 1'b0);
        expect_beat("po_trl", lanes(32'hFFFFFFFC, 32'h0), trl_keep(), 6'd2, 1'b1);
        rnd_rdy = 1'b0;
        expect_empty("po_tail");
`ifdef CHKSUM_STATS_EN
        total++;
        assert (pkt_count === 32'd1 && bypass_count === 32'd0) else begin
            bad++;
            $error("FAIL stats2: got pkt=%0d byp=%0d want 1 0", pkt_count, bypass_count);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
